// File: rtl/level_sensor_filter.sv
`default_nettype none
// ============================================================================
// Module   : level_sensor_filter
// Purpose  : Debounces a three-probe water level sensor. Each probe bit is
//            brought into the clock domain by a two-flop synchronizer; a
//            small STABLE/CHECK state machine then accepts a new level only
//            after DEB_CYCLES consecutive identical samples that differ from
//            the currently accepted level.
// Options  : CONSISTENCY_CHECK_EN - when defined, an accepted candidate that
//            is not a physically possible level (anything other than 000,
//            001, 011, 111) is rejected: level is kept and err strobes for
//            one cycle instead of change_pulse. When undefined, every
//            candidate is accepted and err is tied low.
// Ports    : clock        - single clock, rising edge
//            reset        - asynchronous, active-high reset
//            sens_in[2:0] - raw probes, [0]=low [1]=mid [2]=high, 1=wet
//            level[2:0]   - debounced accepted level (registered)
//            level_valid  - 1 while no candidate change is pending
//            change_pulse - one-cycle strobe on every update of level
//            err          - one-cycle strobe on a rejected inconsistent level
// Revision : 1.0 - initial release
// ============================================================================
module level_sensor_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] sens_in,
    output logic [2:0] level,
    output logic       level_valid,
    output logic       change_pulse,
    output logic       err
);

    // Terminal count: the first matching sample loads cnt=1, so the
    // DEB_CYCLES-th consecutive sample is seen while cnt == DEB_CYCLES-1.
    localparam logic [7:0] c_CNT_LAST = 8'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_sync1;
    logic [2:0] r_samp;
    logic [2:0] r_cand;
    logic [2:0] w_cand_next;
    logic [2:0] r_level;
    logic [2:0] w_level_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_valid;
    logic       w_valid_next;
    logic       r_pulse;
    logic       w_pulse_next;

`ifdef CONSISTENCY_CHECK_EN
    logic       w_cand_bad;
    logic       r_err;
    logic       w_err_next;

    // Probes are stacked, so only "filled from the bottom" codes are real.
    always_comb begin
        w_cand_bad = !((r_cand == 3'b000) || (r_cand == 3'b001) ||
                       (r_cand == 3'b011) || (r_cand == 3'b111));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Two-flop synchronizer per probe bit; r_samp is the sampled value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_samp  <= 3'b000;
        end else begin
            r_sync1 <= sens_in;
            r_samp  <= r_sync1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= STABLE;
            r_cand  <= 3'b000;
            r_cnt   <= 8'd0;
            r_level <= 3'b000;
            r_valid <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_valid <= w_valid_next;
            r_pulse <= w_pulse_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_pulse_next = 1'b0;
`ifdef CONSISTENCY_CHECK_EN
        w_err_next   = 1'b0;
`endif
        case (r_state)
            STABLE: begin
                if (r_samp != r_level) begin
                    w_cand_next  = r_samp;
                    w_cnt_next   = 8'd1;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (r_samp == r_level) begin
                    // Glitch: input fell back to the accepted level.
                    w_cnt_next   = 8'd0;
                    w_state_next = STABLE;
                end else if (r_samp != r_cand) begin
                    // A third value appeared: restart the run on it.
                    w_cand_next = r_samp;
                    w_cnt_next  = 8'd1;
                end else if (r_cnt < c_CNT_LAST) begin
                    w_cnt_next = r_cnt + 8'd1;
                end else begin
                    w_cnt_next   = 8'd0;
                    w_state_next = STABLE;
`ifdef CONSISTENCY_CHECK_EN
                    if (w_cand_bad) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_level_next = r_cand;
                        w_pulse_next = 1'b1;
                    end
`else
                    w_level_next = r_cand;
                    w_pulse_next = 1'b1;
`endif
                end
            end
            default: begin
                w_cnt_next   = 8'd0;
                w_state_next = STABLE;
            end
        endcase
        // Valid goes low in the cycle after a candidate is first seen.
        w_valid_next = (w_state_next == STABLE);
    end

    assign level        = r_level;
    assign level_valid  = r_valid;
    assign change_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_level_sensor_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_sensor_filter
// Purpose  : Self-checking bench for level_sensor_filter (DEB_CYCLES=4).
//            A reference model tracks run lengths of sampled values and
//            is compared against the DUT after every clock edge; directed
//            table vectors and hand-written sequences cover the corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_sensor_filter;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] sens_in;
    logic [2:0] level;
    logic       level_valid;
    logic       change_pulse;
    logic       err;

    level_sensor_filter #(.DEB_CYCLES(DEB)) dut (
        .clock        (clock),
        .reset        (reset),
        .sens_in      (sens_in),
        .level        (level),
        .level_valid  (level_valid),
        .change_pulse (change_pulse),
        .err          (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt;
    int err_cnt;

    // ------------------------------------------------------------------
    // Reference model: a new level is taken when the last DEB sampled
    // values are identical and differ from the accepted level.
    // ------------------------------------------------------------------
    logic [2:0] m_s1, m_samp, m_prev, m_level;
    int         m_run;
    logic       m_valid, m_pulse, m_err;

    function automatic bit consistent(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_samp = 0; m_prev = 0; m_level = 0; m_run = 0;
        m_valid = 1; m_pulse = 0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [2:0] s;
        bit ok;
        s = m_samp;
        m_pulse = 0;
        m_err = 0;
        if (m_run > 0 && s == m_prev) begin
            if (m_run < DEB) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = s;
        if (s != m_level && m_run >= DEB) begin
            ok = 1;
`ifdef CONSISTENCY_CHECK_EN
            ok = consistent(s);
`endif
            if (ok) begin
                m_level = s;
                m_pulse = 1;
            end else begin
                m_err = 1;
            end
            m_run = 0;
        end
        m_valid = (s == m_level) || m_err;
        m_samp = m_s1;
        m_s1 = sens_in;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " level"}, {5'd0, level}, {5'd0, m_level});
        check({tag, " valid"}, {7'd0, level_valid}, {7'd0, m_valid});
        check({tag, " pulse"}, {7'd0, change_pulse}, {7'd0, m_pulse});
        check({tag, " err"}, {7'd0, err}, {7'd0, m_err});
        check({tag, " excl"}, {7'd0, change_pulse & err}, 8'd0);
    endtask

    // One clock edge: advance model, then compare 1ns after the edge.
    task automatic tick(input string tag);
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
        if (change_pulse) pulse_cnt++;
        if (err) err_cnt++;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sens_in = 3'b000;
        model_reset();
        repeat (2) tick("rst");
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0] sens;
        int         hold;
        logic [2:0] exp_level;
        int         exp_pulses;
        int         exp_errs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        reset   = 1'b1;
        sens_in = 3'b000;
        model_reset();
        pulse_cnt = 0;
        err_cnt = 0;

        // Reset state
        #2;
        check("reset level", {5'd0, level}, 8'd0);
        check("reset valid", {7'd0, level_valid}, 8'd1);
        check("reset pulse", {7'd0, change_pulse}, 8'd0);
        check("reset err", {7'd0, err}, 8'd0);
        do_reset();

        // ---------------- table-driven vectors ----------------
        vecs[0] = '{3'b001, 8, 3'b001, 1, 0};
        vecs[1] = '{3'b011, 2, 3'b001, 0, 0};
        vecs[2] = '{3'b001, 6, 3'b001, 0, 0};
        vecs[3] = '{3'b011, 2, 3'b001, 0, 0};
        vecs[4] = '{3'b111, 8, 3'b111, 1, 0};
`ifdef CONSISTENCY_CHECK_EN
        vecs[5] = '{3'b101, 8, 3'b111, 0, 1};
        vecs[6] = '{3'b000, 8, 3'b000, 1, 1};
`else
        vecs[5] = '{3'b101, 8, 3'b101, 1, 0};
        vecs[6] = '{3'b000, 8, 3'b000, 1, 0};
`endif
        vecs[7] = '{3'b010, 3, 3'b000, 0, 0};
        vecs[8] = '{3'b000, 6, 3'b000, 0, 0};

        for (int i = 0; i < 9; i++) begin
            sens_in = vecs[i].sens;
            pulse_cnt = 0;
            err_cnt = 0;
            for (int k = 0; k < vecs[i].hold; k++) tick("vec");
            check($sformatf("vec%0d level", i), {5'd0, level}, {5'd0, vecs[i].exp_level});
            check($sformatf("vec%0d pulses", i), 8'(pulse_cnt), 8'(vecs[i].exp_pulses));
            check($sformatf("vec%0d errs", i), 8'(err_cnt), 8'(vecs[i].exp_errs));
        end

        // ---------------- exact latency after reset ----------------
        do_reset();
        sens_in = 3'b001;
        for (int e = 1; e <= 6; e++) begin
            tick("lat");
            check($sformatf("lat e%0d level", e), {5'd0, level}, (e == 6) ? 8'd1 : 8'd0);
            check($sformatf("lat e%0d valid", e), {7'd0, level_valid},
                  (e >= 3 && e <= 5) ? 8'd0 : 8'd1);
            check($sformatf("lat e%0d pulse", e), {7'd0, change_pulse}, (e == 6) ? 8'd1 : 8'd0);
        end
        repeat (2) tick("lat post");
        check("lat pulse once", {7'd0, change_pulse}, 8'd0);

        // ---------------- async reset mid-CHECK ----------------
        sens_in = 3'b011;
        repeat (4) tick("mid");  // FSM has seen 011 twice: cnt == 2
        check("mid valid low", {7'd0, level_valid}, 8'd0);
        check("mid level", {5'd0, level}, 8'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async level", {5'd0, level}, 8'd0);
        check("async valid", {7'd0, level_valid}, 8'd1);
        check("async pulse", {7'd0, change_pulse}, 8'd0);
        check("async err", {7'd0, err}, 8'd0);
        tick("held rst");
        reset = 1'b0;
        begin
            int edges;
            edges = 0;
            while (level != 3'b011 && edges < 20) begin
                tick("rel");
                edges++;
            end
            check("release latency", 8'(edges), 8'd6);
        end

        // ---------------- randomized ----------------
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 3) == 0)
                sens_in = 3'($urandom_range(0, 7));
            else
                case ($urandom_range(0, 3))
                    0: sens_in = 3'b000;
                    1: sens_in = 3'b001;
                    2: sens_in = 3'b011;
                    default: sens_in = 3'b111;
                endcase
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) tick("rnd");
            if ($urandom_range(0, 19) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_model("rnd rst");
                reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
